axi4_lite_write_master_q: RTL and testbench

Queued, parametrised AXI4-Lite write master. It buffers core write requests in a FIFO and issues the AW and W channels independently. It allows up to MAX_OUTSTANDING writes awaiting B responses, and reports per-write completion, response code and a sticky error flag. It replaces the single-shot write master on the core's data-memory/peripheral write path.

---
 rtl/axi4_lite_write_master_q.sv | 166 ++++++++++++++++
 tb/tb_axi4_lite_write_master_q.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_write_master_q.sv
`default_nettype none
// ============================================================================
// axi4_lite_write_master_q
// Queued AXI4-Lite write master: request FIFO, independent AW/W issue and a
// bounded number of writes awaiting their B response.
// Revision: 1.0
// ============================================================================
module axi4_lite_write_master_q #(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int FIFO_DEPTH      = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int STRB_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_start,
    output logic                  write_ready,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [STRB_WIDTH-1:0] write_strobe,
    output logic                  write_busy,
    output logic                  write_done,
    output logic [1:0]            write_resp,
    output logic                  write_err,
    input  logic                  err_clear,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic [1:0]            resp_q, resp_d;

    logic                  w_push, w_pop, w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_empty, w_full_next, w_can_issue;
    logic [ENT_W-1:0]      w_head;

    assign w_empty     = (wr_ptr_q == rd_ptr_q);
    assign w_head      = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign w_push      = write_start && ready_q;
    assign w_aw_hs     = aw_valid_q && M_AXI_AWREADY;
    assign w_w_hs      = w_valid_q && M_AXI_WREADY;
    assign w_b_hs      = M_AXI_BVALID && (count_q != '0);
    // The head retires once both of its channels have handshaken, in any order.
    assign w_pop       = (w_aw_hs || aw_done_q) && (w_w_hs || w_done_q);
    assign w_can_issue = !w_empty && (count_q < CNT_W'(MAX_OUTSTANDING));
    assign w_full_next = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                         (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, w_push};
        rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, w_pop};
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        count_d    = count_q;

        if (w_aw_hs) begin
            aw_valid_d = 1'b0;
        end else if (!aw_valid_q && !aw_done_q && w_can_issue) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = w_head[ENT_W-1 -: ADDR_WIDTH];
        end

        if (w_w_hs) begin
            w_valid_d = 1'b0;
        end else if (!w_valid_q && !w_done_q && w_can_issue) begin
            w_valid_d = 1'b1;
            w_data_d  = w_head[STRB_WIDTH +: DATA_WIDTH];
            w_strb_d  = w_head[STRB_WIDTH-1:0];
        end

        aw_done_d = w_pop ? 1'b0 : (aw_done_q || w_aw_hs);
        w_done_d  = w_pop ? 1'b0 : (w_done_q || w_w_hs);

        if (w_pop && !w_b_hs) begin
            count_d = count_q + 1'b1;
        end else if (!w_pop && w_b_hs) begin
            count_d = count_q - 1'b1;
        end

        done_d  = w_b_hs;
        resp_d  = w_b_hs ? M_AXI_BRESP : resp_q;
        // A new error outranks a coincident clear.
        err_d   = (w_b_hs && (M_AXI_BRESP != 2'b00)) || (err_q && !err_clear);
        ready_d = !w_full_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            count_q    <= '0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            count_q    <= count_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
        end
    end

    // Payload storage needs no reset; occupancy lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {write_addr, write_data, write_strobe};
        end
    end

    assign write_ready   = ready_q;
    assign write_busy    = !w_empty || aw_valid_q || w_valid_q || aw_done_q ||
                           w_done_q || (count_q != '0);
    assign write_done    = done_q;
    assign write_resp    = resp_q;
    assign write_err     = err_q;
    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWVALID = aw_valid_q;
    assign M_AXI_WDATA   = w_data_q;
    assign M_AXI_WSTRB   = w_strb_q;
    assign M_AXI_WVALID  = w_valid_q;
    assign M_AXI_BREADY  = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_write_master_q.sv
`default_nettype none
// ============================================================================
// tb_axi4_lite_write_master_q
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model and a randomized AXI4-Lite slave.
// Revision: 1.0
// ============================================================================
module tb_axi4_lite_write_master_q;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_start, write_ready, write_busy, write_done, write_err, err_clear;
    logic [31:0] write_addr, write_data;
    logic [3:0]  write_strobe;
    logic [1:0]  write_resp;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  bresp;

    always #5 clk = ~clk;

    axi4_lite_write_master_q #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .write_start(write_start), .write_ready(write_ready),
        .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe),
        .write_busy(write_busy), .write_done(write_done), .write_resp(write_resp),
        .write_err(write_err), .err_clear(err_clear),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } req_t;

    // Reference model: accepted requests flow to AW and W in order; every
    // accepted request eventually yields exactly one B.
    req_t        aw_exp[$], w_exp[$];
    int          n_acc, n_aw, n_w, n_b;
    logic        exp_done, err_m;
    logic [1:0]  last_resp;
    int          n_cmp, n_err;

    logic        prev_awv, prev_aw_hs, prev_wv, prev_w_hs;
    logic [31:0] prev_awaddr, prev_wdata;
    logic [3:0]  prev_wstrb;

    int          aw_pct, w_pct, b_pct;
    bit          b_hold, rand_resp, clr_on_err;
    int          bplan[$];

    function automatic int pairs();
        return (n_aw < n_w) ? n_aw : n_w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit   aw_hs, w_hs, b_hs, acc;
        int   outst, pend;
        req_t r;
        outst = pairs() - n_b;
        chk("bready", 64'(bready), 64'(outst != 0));
        chk("write_ready", 64'(write_ready), 64'((n_acc - pairs()) < DEPTH));
        chk("write_busy", 64'(write_busy), 64'(n_acc != n_b));
        chk("write_done", 64'(write_done), 64'(exp_done));
        chk("write_resp", 64'(write_resp), 64'(last_resp));
        chk("write_err", 64'(write_err), 64'(err_m));
        if (prev_awv && !prev_aw_hs) begin
            chk("aw_hold", 64'(awvalid), 64'(1));
            chk("aw_addr_stable", 64'(awaddr), 64'(prev_awaddr));
        end
        if (prev_wv && !prev_w_hs) begin
            chk("w_hold", 64'(wvalid), 64'(1));
            chk("w_data_stable", 64'({wdata, wstrb}), 64'({prev_wdata, prev_wstrb}));
        end
        if (prev_aw_hs) chk("aw_gap", 64'(awvalid), 64'(0));
        if (prev_w_hs)  chk("w_gap", 64'(wvalid), 64'(0));
        if (awvalid) begin
            chk("aw_limit", 64'(outst < MAXO), 64'(1));
            chk("aw_spurious", 64'(aw_exp.size() != 0), 64'(1));
        end
        if (wvalid) begin
            chk("w_limit", 64'(outst < MAXO), 64'(1));
            chk("w_spurious", 64'(w_exp.size() != 0), 64'(1));
        end

        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        acc   = write_start && write_ready;
        if (clr_on_err && b_hs && bresp != 2'b00) err_clear = 1'b1;

        if (aw_hs && aw_exp.size() != 0) begin
            r = aw_exp.pop_front();
            chk("awaddr", 64'(awaddr), 64'(r.a));
        end
        if (w_hs && w_exp.size() != 0) begin
            r = w_exp.pop_front();
            chk("wdata", 64'({wdata, wstrb}), 64'({r.d, r.s}));
        end
        if (aw_hs) n_aw++;
        if (w_hs)  n_w++;
        if (acc) begin
            r = '{a: write_addr, d: write_data, s: write_strobe};
            aw_exp.push_back(r);
            w_exp.push_back(r);
            n_acc++;
        end
        exp_done = b_hs;
        if (b_hs) begin
            last_resp = bresp;
            n_b++;
        end
        err_m = (b_hs && bresp != 2'b00) ? 1'b1 : (err_clear ? 1'b0 : err_m);

        prev_awv = awvalid; prev_aw_hs = aw_hs; prev_awaddr = awaddr;
        prev_wv  = wvalid;  prev_w_hs  = w_hs;  prev_wdata  = wdata; prev_wstrb = wstrb;

        @(posedge clk);
        #1;
        write_start = 1'b0;
        err_clear   = 1'b0;
        awready = int'($urandom_range(99)) < aw_pct;
        wready  = int'($urandom_range(99)) < w_pct;
        // B may only follow a write whose AW and W have both completed.
        pend = pairs() - n_b;
        if (!bvalid || b_hs) begin
            if (pend > 0 && !b_hold && int'($urandom_range(99)) < b_pct) begin
                bvalid = 1'b1;
                if (bplan.size() != 0) bresp = 2'(bplan.pop_front());
                else                   bresp = rand_resp ? 2'($urandom_range(3)) : 2'b00;
            end else begin
                bvalid = 1'b0;
            end
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        write_start  = 1'b1;
        write_addr   = a;
        write_data   = d;
        write_strobe = s;
        tick();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (n_b != n_acc && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", 64'(n_b == n_acc), 64'(1));
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        write_start = 1'b0; err_clear = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", 64'(awvalid), 64'(0));
        chk("rst_wvalid", 64'(wvalid), 64'(0));
        chk("rst_bready", 64'(bready), 64'(0));
        chk("rst_done", 64'(write_done), 64'(0));
        chk("rst_resp", 64'(write_resp), 64'(0));
        chk("rst_busy", 64'(write_busy), 64'(0));
        chk("rst_ready", 64'(write_ready), 64'(0));
        chk("rst_err", 64'(write_err), 64'(0));
        aw_exp.delete(); w_exp.delete(); bplan.delete();
        n_acc = 0; n_aw = 0; n_w = 0; n_b = 0;
        exp_done = 1'b0; err_m = 1'b0; last_resp = 2'b00;
        prev_awv = 1'b0; prev_aw_hs = 1'b0; prev_wv = 1'b0; prev_w_hs = 1'b0;
        prev_awaddr = '0; prev_wdata = '0; prev_wstrb = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        write_addr = '0; write_data = '0; write_strobe = '0;
        aw_pct = 100; w_pct = 100; b_pct = 100;
        b_hold = 1'b0; rand_resp = 1'b0; clr_on_err = 1'b0;
        do_reset();

        // Single write
        push(32'h1000, 32'hDEADBEEF, 4'hF);
        drain(100);
        chk("single_busy", 64'(write_busy), 64'(0));
        chk("single_resp", 64'(write_resp), 64'(0));

        // Fill the FIFO while the slave stalls, then an ignored fifth request
        aw_pct = 0; w_pct = 0;
        for (int i = 0; i < 4; i++) push(32'h2000 + 32'(i), 32'hCAFEBABE + 32'(i), 4'hF);
        chk("full_ready", 64'(write_ready), 64'(0));
        push(32'h2FFF, 32'h0BADF00D, 4'h3);
        aw_pct = 100; w_pct = 100;
        drain(200);

        // W completes well before AW
        b_hold = 1'b1; aw_pct = 0; w_pct = 100;
        push(32'h3000, 32'h13572468, 4'h5);
        repeat (5) tick();
        chk("wfirst_wvalid", 64'(wvalid), 64'(0));
        chk("wfirst_awvalid", 64'(awvalid), 64'(1));
        chk("wfirst_bready", 64'(bready), 64'(0));
        aw_pct = 100;
        repeat (3) tick();
        chk("wfirst_count1", 64'(bready), 64'(1));
        chk("wfirst_awdone", 64'(awvalid), 64'(0));
        b_hold = 1'b0;
        drain(100);

        // Outstanding limit blocks the third write until a B arrives
        b_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h4000 + 32'(4 * i), 32'h40000000 + 32'(i), 4'hF);
        repeat (15) tick();
        chk("limit_awvalid", 64'(awvalid), 64'(0));
        chk("limit_wvalid", 64'(wvalid), 64'(0));
        chk("limit_bready", 64'(bready), 64'(1));
        b_hold = 1'b0;
        drain(200);

        // Error response on the second of three, sticky flag and clearing
        bplan = '{0, 2, 0};
        for (int i = 0; i < 3; i++) push(32'h5000 + 32'(4 * i), 32'h50000000 + 32'(i), 4'hF);
        drain(200);
        chk("err_sticky", 64'(write_err), 64'(1));
        chk("err_last_resp", 64'(write_resp), 64'(0));
        err_clear = 1'b1;
        tick();
        chk("err_cleared", 64'(write_err), 64'(0));
        clr_on_err = 1'b1;
        bplan = '{2};
        push(32'h5100, 32'h51000000, 4'hF);
        drain(100);
        clr_on_err = 1'b0;
        chk("err_set_wins", 64'(write_err), 64'(1));
        chk("err_resp10", 64'(write_resp), 64'(2));

        // Reset with one write outstanding and AWVALID pending
        b_hold = 1'b1;
        push(32'h6000, 32'h60000000, 4'hF);
        repeat (4) tick();
        aw_pct = 0;
        push(32'h6004, 32'h60000004, 4'hF);
        repeat (2) tick();
        chk("mid_awvalid", 64'(awvalid), 64'(1));
        do_reset();
        b_hold = 1'b0; aw_pct = 100;
        push(32'h7000, 32'h77777777, 4'hC);
        drain(100);

        // Randomized traffic
        rand_resp = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                aw_pct = 20 + int'($urandom_range(80));
                w_pct  = 20 + int'($urandom_range(80));
                b_pct  = 20 + int'($urandom_range(80));
            end
            write_start  = int'($urandom_range(99)) < 40;
            write_addr   = $urandom;
            write_data   = $urandom;
            write_strobe = 4'($urandom_range(15));
            err_clear    = int'($urandom_range(99)) < 3;
            tick();
        end
        drain(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
